// File: rtl/camera_ray_gen.sv
// camera_ray_gen: pinhole-camera primary ray source for the ray tracer.
// It walks an IMG_W x IMG_H raster in row-major order after a start pulse.
// For each pixel it writes one six-word ray into the downstream ray FIFO.
// Ray directions are stepped incrementally, so no multipliers are needed.
module camera_ray_gen #(
    parameter int D_BITS   = 32,
    parameter int Q_BITS   = 10,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int CAM_X    = 0,
    parameter int CAM_Y    = 0,
    parameter int CAM_Z    = 0,
    parameter int FOCAL    = 1024,
    parameter int PIX_STEP = 32,
    localparam int PX_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int PY_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    out_full,
    output logic                    out_wr_en,
    output logic [5:0][D_BITS-1:0]  ray_out,
    output logic [PX_W-1:0]         pixel_x,
    output logic [PY_W-1:0]         pixel_y,
    output logic                    busy,
    output logic                    done
);

    // Parameter sanity: a fractional field as wide as the word leaves no
    // integer part, and a raster needs at least one pixel per axis.
    if (Q_BITS < 0 || Q_BITS >= D_BITS) begin : g_bad_q
        $error("camera_ray_gen: Q_BITS must be in [0, D_BITS)");
    end
    if (IMG_W < 1 || IMG_H < 1) begin : g_bad_img
        $error("camera_ray_gen: IMG_W and IMG_H must be at least 1");
    end

    // Start-of-row / start-of-frame directions: the raster is centred on the
    // optical axis, x grows to the right, y shrinks going down the frame.
    localparam logic signed [D_BITS-1:0] DIR_X0 = D_BITS'(-(IMG_W * PIX_STEP) / 2);
    localparam logic signed [D_BITS-1:0] DIR_Y0 = D_BITS'((IMG_H * PIX_STEP) / 2);
    localparam logic signed [D_BITS-1:0] STEP   = D_BITS'(PIX_STEP);
    localparam logic signed [D_BITS-1:0] DIR_Z  = D_BITS'(FOCAL);
    localparam logic [2:0][D_BITS-1:0] CAM_ORIGIN =
        {D_BITS'(CAM_Z), D_BITS'(CAM_Y), D_BITS'(CAM_X)};
    localparam logic [PX_W-1:0] X_LAST = PX_W'(IMG_W - 1);
    localparam logic [PY_W-1:0] Y_LAST = PY_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [PX_W-1:0]           px_q, px_d;
    logic [PY_W-1:0]           py_q, py_d;
    logic signed [D_BITS-1:0]  dir_x_q, dir_x_d;
    logic signed [D_BITS-1:0]  dir_y_q, dir_y_d;

    // A write happens whenever the walker is running and the FIFO has room.
    assign out_wr_en = (state_q == S_RUN) && !out_full;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pixel_x   = px_q;
    assign pixel_y   = py_q;

    // Origin words are fixed; one assignment per axis.
    for (genvar gi = 0; gi < 3; gi++) begin : g_origin
        assign ray_out[gi] = CAM_ORIGIN[gi];
    end
    assign ray_out[3] = dir_x_q;
    assign ray_out[4] = dir_y_q;
    assign ray_out[5] = DIR_Z;

    // Next-state logic: FSM plus raster counters and direction stepping.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (out_wr_en) begin
                    if (px_q == X_LAST) begin
                        px_d    = '0;
                        dir_x_d = DIR_X0;
                        if (py_q == Y_LAST) begin
                            // Final pixel: rewind everything for the next frame.
                            py_d    = '0;
                            dir_y_d = DIR_Y0;
                            state_d = S_DONE;
                        end else begin
                            py_d    = py_q + PY_W'(1);
                            dir_y_d = dir_y_q - STEP;
                        end
                    end else begin
                        px_d    = px_q + PX_W'(1);
                        dir_x_d = dir_x_q + STEP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and raster registers; reset abandons any partial frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            dir_x_q <= DIR_X0;
            dir_y_q <= DIR_Y0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

endmodule

// File: tb/tb_camera_ray_gen.sv
// Bench for camera_ray_gen: three instances (4x2 frame, default 64x64
// frame, 1x1 frame) with a per-instance scoreboard of expected rays.
module tb_camera_ray_gen;

    typedef logic [5:0][31:0] ray_t;
    typedef struct {
        int   px;
        int   py;
        ray_t ray;
    } item_t;

    logic clk;
    logic rst_n;
    logic a_start, a_full, b_start, b_full, c_start, c_full;

    logic        a_wr, a_busy, a_done;
    ray_t        a_ray;
    logic [1:0]  a_px;
    logic [0:0]  a_py;
    logic        b_wr, b_busy, b_done;
    ray_t        b_ray;
    logic [5:0]  b_px;
    logic [5:0]  b_py;
    logic        c_wr, c_busy, c_done;
    ray_t        c_ray;
    logic [0:0]  c_px;
    logic [0:0]  c_py;

    int vec  = 0;
    int errs = 0;

    camera_ray_gen #(
        .D_BITS(32), .Q_BITS(10), .IMG_W(4), .IMG_H(2),
        .CAM_X(5), .CAM_Y(-7), .CAM_Z(9), .FOCAL(1024), .PIX_STEP(256)
    ) u_a (
        .clock(clk), .reset(rst_n), .start(a_start), .out_full(a_full),
        .out_wr_en(a_wr), .ray_out(a_ray), .pixel_x(a_px), .pixel_y(a_py),
        .busy(a_busy), .done(a_done)
    );

    camera_ray_gen u_b (
        .clock(clk), .reset(rst_n), .start(b_start), .out_full(b_full),
        .out_wr_en(b_wr), .ray_out(b_ray), .pixel_x(b_px), .pixel_y(b_py),
        .busy(b_busy), .done(b_done)
    );

    camera_ray_gen #(
        .IMG_W(1), .IMG_H(1)
    ) u_c (
        .clock(clk), .reset(rst_n), .start(c_start), .out_full(c_full),
        .out_wr_en(c_wr), .ray_out(c_ray), .pixel_x(c_px), .pixel_y(c_py),
        .busy(c_busy), .done(c_done)
    );

    // Uniform views of the three instances for the monitor.
    logic       m_wr   [3];
    logic       m_full [3];
    logic       m_done [3];
    ray_t       m_ray  [3];
    logic [7:0] m_px   [3];
    logic [7:0] m_py   [3];
    assign m_wr[0] = a_wr;  assign m_full[0] = a_full; assign m_done[0] = a_done;
    assign m_wr[1] = b_wr;  assign m_full[1] = b_full; assign m_done[1] = b_done;
    assign m_wr[2] = c_wr;  assign m_full[2] = c_full; assign m_done[2] = c_done;
    assign m_ray[0] = a_ray; assign m_px[0] = 8'(a_px); assign m_py[0] = 8'(a_py);
    assign m_ray[1] = b_ray; assign m_px[1] = 8'(b_px); assign m_py[1] = 8'(b_py);
    assign m_ray[2] = c_ray; assign m_px[2] = 8'(c_px); assign m_py[2] = 8'(c_py);

    item_t sb [3][$];
    int    wcnt     [3];
    logic  exp_done [3];
    ray_t  last_ray [3];
    int    last_px  [3];
    int    last_py  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ray from the closed-form pinhole model.
    function automatic ray_t mk_ray(input int px, input int py, input int w, input int h,
                                    input int s, input int cx, input int cy, input int cz,
                                    input int f);
        ray_t r;
        r[0] = cx;
        r[1] = cy;
        r[2] = cz;
        r[3] = -(w * s) / 2 + px * s;
        r[4] = (h * s) / 2 - py * s;
        r[5] = f;
        return r;
    endfunction

    task automatic push_frame(input int i, input int w, input int h, input int s,
                              input int cx, input int cy, input int cz);
        item_t it;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                it.px  = x;
                it.py  = y;
                it.ray = mk_ray(x, y, w, h, s, cx, cy, cz, 1024);
                sb[i].push_back(it);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_writes(input int i, input int target, input int budget);
        int n = 0;
        while (wcnt[i] < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("wait_writes_%0d", i), 192'(wcnt[i] >= target), 192'(1));
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (m_done[i] !== 1'b1 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("done_seen_%0d", i), 192'(m_done[i]), 192'(1));
    endtask

    // Monitor: every write is matched against the scoreboard head; done must
    // follow the write that drains the scoreboard by exactly one cycle.
    initial begin
        for (int i = 0; i < 3; i++) begin
            wcnt[i] = 0;
            exp_done[i] = 1'b0;
            last_px[i] = 0;
            last_py[i] = 0;
            last_ray[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                item_t it;
                chk($sformatf("done_timing_%0d", i), 192'(m_done[i]), 192'(exp_done[i]));
                exp_done[i] = 1'b0;
                if (m_full[i]) begin
                    chk($sformatf("stall_wr_%0d", i), 192'(m_wr[i]), 192'(0));
                end
                if (m_wr[i] === 1'b1) begin
                    wcnt[i]++;
                    chk($sformatf("write_expected_%0d", i), 192'(sb[i].size() > 0), 192'(1));
                    if (sb[i].size() > 0) begin
                        it = sb[i].pop_front();
                        chk($sformatf("px_%0d", i), 192'(m_px[i]), 192'(it.px));
                        chk($sformatf("py_%0d", i), 192'(m_py[i]), 192'(it.py));
                        chk($sformatf("ray_%0d", i), m_ray[i], it.ray);
                        last_ray[i] = m_ray[i];
                        last_px[i]  = int'(m_px[i]);
                        last_py[i]  = int'(m_py[i]);
                        if (sb[i].size() == 0) exp_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        ray_t a_rst;
        rst_n = 1'b0;
        a_start = 1'b0; a_full = 1'b0;
        b_start = 1'b0; b_full = 1'b0;
        c_start = 1'b0; c_full = 1'b0;
        a_rst = mk_ray(0, 0, 4, 2, 256, 5, -7, 9, 1024);

        // Reset values.
        @(negedge clk);
        #1;
        chk("rst_wr", 192'(a_wr), 192'(0));
        chk("rst_busy", 192'(a_busy), 192'(0));
        chk("rst_done", 192'(a_done), 192'(0));
        chk("rst_px", 192'(a_px), 192'(0));
        chk("rst_py", 192'(a_py), 192'(0));
        chk("rst_ray_a", a_rst, a_ray);
        chk("rst_ray_b", b_ray, mk_ray(0, 0, 64, 64, 32, 0, 0, 0, 1024));
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(3);
        chk("idle_no_write", 192'(wcnt[0]), 192'(0));

        // Plain 4x2 frame: eight back-to-back writes, then done.
        base = wcnt[0];
        push_frame(0, 4, 2, 256, 5, -7, 9);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        chk("s1_busy", 192'(a_busy), 192'(1));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("s1_wr_%0d", k), 192'(a_wr), 192'(1));
            cyc(1);
        end
        chk("s1_done", 192'(a_done), 192'(1));
        chk("s1_done_busy", 192'(a_busy), 192'(0));
        chk("s1_done_wr", 192'(a_wr), 192'(0));
        cyc(1);
        chk("s1_done_drop", 192'(a_done), 192'(0));
        chk("s1_count", 192'(wcnt[0] - base), 192'(8));

        // Stalls after the 3rd write and at the row wrap.
        base = wcnt[0];
        push_frame(0, 4, 2, 256, 5, -7, 9);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        wait_writes(0, base + 3, 20);
        @(posedge clk);
        #1 a_full = 1'b1;
        #1 chk("s2_full_blocks", 192'(a_wr), 192'(0));
        cyc(3);
        a_full = 1'b0;
        wait_writes(0, base + 4, 20);
        @(posedge clk);
        #1 a_full = 1'b1;
        #1 chk("s2_full_px", 192'(a_px), 192'(0));
        cyc(3);
        a_full = 1'b0;
        wait_done(0, 40);
        chk("s2_count", 192'(wcnt[0] - base), 192'(8));
        chk("s2_sb_empty", 192'(sb[0].size()), 192'(0));
        cyc(1);

        // Start pulses in RUN and DONE are ignored; restart right after done.
        base = wcnt[0];
        push_frame(0, 4, 2, 256, 5, -7, 9);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        wait_writes(0, base + 4, 20);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        wait_done(0, 40);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        chk("s3_ignored_in_done", 192'(a_busy), 192'(0));
        chk("s3_count", 192'(wcnt[0] - base), 192'(8));
        base = wcnt[0];
        push_frame(0, 4, 2, 256, 5, -7, 9);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        chk("s3_restart_busy", 192'(a_busy), 192'(1));
        chk("s3_restart_dirx", 192'(a_ray[3]), 192'(32'hFFFF_FE00));
        wait_done(0, 40);
        chk("s3_restart_count", 192'(wcnt[0] - base), 192'(8));
        cyc(1);

        // Asynchronous reset after the 5th write.
        base = wcnt[0];
        push_frame(0, 4, 2, 256, 5, -7, 9);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        wait_writes(0, base + 5, 20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wr", 192'(a_wr), 192'(0));
        chk("ar_busy", 192'(a_busy), 192'(0));
        chk("ar_done", 192'(a_done), 192'(0));
        chk("ar_px", 192'(a_px), 192'(0));
        chk("ar_py", 192'(a_py), 192'(0));
        chk("ar_ray", a_ray, a_rst);
        sb[0].delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(4);
        chk("ar_no_writes", 192'(wcnt[0] - base), 192'(5));
        chk("ar_idle", 192'(a_busy), 192'(0));
        push_frame(0, 4, 2, 256, 5, -7, 9);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        chk("ar_restart_px", 192'(a_px), 192'(0));
        chk("ar_restart_py", 192'(a_py), 192'(0));
        wait_done(0, 40);
        chk("ar_restart_count", 192'(wcnt[0] - base), 192'(13));

        // Default 64x64 frame, free running.
        base = wcnt[1];
        push_frame(1, 64, 64, 32, 0, 0, 0);
        b_start = 1'b1;
        cyc(1);
        b_start = 1'b0;
        chk("b_first_dirx", 192'(b_ray[3]), 192'(32'hFFFF_FC00));
        chk("b_first_diry", 192'(b_ray[4]), 192'(32'd1024));
        chk("b_first_dirz", 192'(b_ray[5]), 192'(32'd1024));
        wait_done(1, 5000);
        chk("b_count", 192'(wcnt[1] - base), 192'(4096));
        chk("b_last_dirx", 192'(last_ray[1][3]), 192'(32'd992));
        chk("b_last_diry", 192'(last_ray[1][4]), 192'(32'hFFFF_FC20));
        chk("b_last_px", 192'(last_px[1]), 192'(63));
        chk("b_last_py", 192'(last_py[1]), 192'(63));

        // Single-pixel frame.
        base = wcnt[2];
        push_frame(2, 1, 1, 32, 0, 0, 0);
        c_start = 1'b1;
        cyc(1);
        c_start = 1'b0;
        chk("c_wr", 192'(c_wr), 192'(1));
        chk("c_ray", c_ray, mk_ray(0, 0, 1, 1, 32, 0, 0, 0, 1024));
        cyc(1);
        chk("c_done", 192'(c_done), 192'(1));
        chk("c_done_wr", 192'(c_wr), 192'(0));
        cyc(1);
        chk("c_idle", 192'(c_done), 192'(0));
        chk("c_count", 192'(wcnt[2] - base), 192'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
